// File: rtl/bambu_mem_initiator.sv
// Single-channel initiator for the Bambu minimal memory interface.
// Takes one host command at a time, runs one strobed access against the
// accelerator's slave memory port and returns one response.
//
// Handshake rule, both channels: a transfer happens on a rising clock edge
// where valid and ready are both high. A valid, once raised, holds its
// payload unchanged until that edge.
module bambu_mem_initiator #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int SIZE_W  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [SIZE_W-1:0] cmd_size,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              M_oe_ram,
    output logic              M_we_ram,
    output logic [ADDR_W-1:0] M_addr_ram,
    output logic [DATA_W-1:0] M_Wdata_ram,
    output logic [SIZE_W-1:0] M_data_ram_size,
    input  logic [DATA_W-1:0] S_Rdata_ram,
    input  logic              S_DataRdy,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Last wait count before giving up: strobe stays up TIMEOUT cycles.
    localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

    state_t             r_state, w_state_nxt;
    logic [15:0]        r_wait_cnt, w_wait_nxt;
    logic               r_cmd_ready, w_cmd_ready_nxt;
    logic               r_rsp_valid, w_rsp_valid_nxt;
    logic               r_rsp_err, w_rsp_err_nxt;
    logic [DATA_W-1:0]  r_rsp_rdata, w_rsp_rdata_nxt;
    logic               r_oe, w_oe_nxt;
    logic               r_we, w_we_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [DATA_W-1:0]  r_wdata, w_wdata_nxt;
    logic [SIZE_W-1:0]  r_size, w_size_nxt;

    logic               w_size_legal;
    logic [DATA_W:0]    w_mask_wide;
    logic [DATA_W-1:0]  w_mask;

    assign w_size_legal = (cmd_size == SIZE_W'(8)) ||
                          (cmd_size == SIZE_W'(16)) ||
                          (cmd_size == SIZE_W'(32));

    // Mask is built one bit wider so a full-width size yields all ones
    // instead of wrapping the shifted one out of the word.
    assign w_mask_wide = ({{DATA_W{1'b0}}, 1'b1} << r_size) - {{DATA_W{1'b0}}, 1'b1};
    assign w_mask      = w_mask_wide[DATA_W-1:0];

    // State and all registered outputs; reset abandons any access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_oe        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_oe        <= w_oe_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_size      <= w_size_nxt;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        w_state_nxt     = r_state;
        w_wait_nxt      = r_wait_cnt;
        w_cmd_ready_nxt = r_cmd_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_oe_nxt        = r_oe;
        w_we_nxt        = r_we;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_size_nxt      = r_size;
        case (r_state)
            IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    if (w_size_legal) begin
                        w_state_nxt = ACCESS;
                        w_oe_nxt    = ~cmd_we;
                        w_we_nxt    = cmd_we;
                        w_addr_nxt  = cmd_addr;
                        w_wdata_nxt = cmd_wdata;
                        w_size_nxt  = cmd_size;
                        w_wait_nxt  = '0;
                    end else begin
                        // Rejected without touching the bus.
                        w_state_nxt     = RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end
                end
            end
            ACCESS: begin
                if (S_DataRdy) begin
                    // DataRdy on the timeout edge still completes normally.
                    w_state_nxt     = RESP;
                    w_oe_nxt        = 1'b0;
                    w_we_nxt        = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = r_oe ? (S_Rdata_ram & w_mask) : '0;
                end else if (r_wait_cnt == LP_LAST) begin
                    w_state_nxt     = RESP;
                    w_oe_nxt        = 1'b0;
                    w_we_nxt        = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end else begin
                    w_wait_nxt = r_wait_cnt + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = '0;
                    w_cmd_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_oe_nxt        = 1'b0;
                w_we_nxt        = 1'b0;
                w_rsp_valid_nxt = 1'b0;
                w_cmd_ready_nxt = 1'b1;
            end
        endcase
    end

    assign cmd_ready       = r_cmd_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_err         = r_rsp_err;
    assign rsp_rdata       = r_rsp_rdata;
    assign M_oe_ram        = r_oe;
    assign M_we_ram        = r_we;
    assign M_addr_ram      = r_addr;
    assign M_Wdata_ram     = r_wdata;
    assign M_data_ram_size = r_size;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_bambu_mem_initiator.sv
// Bench for bambu_mem_initiator: directed vector table, hand-written
// multi-cycle sequences, then randomized commands against a reference model.
module tb_bambu_mem_initiator;

    localparam int TMO = 4;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [5:0]  cmd_size;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        M_oe_ram;
    logic        M_we_ram;
    logic [11:0] M_addr_ram;
    logic [31:0] M_Wdata_ram;
    logic [5:0]  M_data_ram_size;
    logic [31:0] S_Rdata_ram;
    logic        S_DataRdy;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    bambu_mem_initiator #(
        .ADDR_W(12), .DATA_W(32), .SIZE_W(6), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .M_oe_ram(M_oe_ram), .M_we_ram(M_we_ram), .M_addr_ram(M_addr_ram),
        .M_Wdata_ram(M_Wdata_ram), .M_data_ram_size(M_data_ram_size),
        .S_Rdata_ram(S_Rdata_ram), .S_DataRdy(S_DataRdy),
        .o_dbg_state(dbg_state)
    );

    // Clock and global time limit.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: what one command should produce, from the access rules only.
    function automatic void model(input logic we, input logic [5:0] size, input int delay,
                                  input logic [31:0] rsrc, output logic err,
                                  output logic [31:0] rdata, output int strobes,
                                  output int lat);
        longint unsigned span;
        if (!(size == 6'd8 || size == 6'd16 || size == 6'd32)) begin
            err = 1'b1; rdata = 32'h0; strobes = 0; lat = 1;
        end else if (delay >= 1 && delay <= TMO) begin
            err = 1'b0; strobes = delay; lat = delay + 1;
            span = 64'd1 << size;
            rdata = we ? 32'h0 : 32'(longint'(rsrc) % span);
        end else begin
            err = 1'b1; rdata = 32'h0; strobes = TMO; lat = TMO + 1;
        end
    endfunction

    // Drive one command, act as the responder, check bus and response.
    // delay = strobe cycle in which DataRdy is raised (0 = never).
    task automatic do_txn(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [5:0] size, input int delay, input logic [31:0] rsrc,
                          input int hold, input logic e_err, input logic [31:0] e_rdata,
                          input int e_strobes, input int e_lat);
        int m, strobes, bad, guard, hbad;
        logic got;
        logic [31:0] exp_rd;
        exp_q.push_back(e_rdata);
        @(negedge clock);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_size = size;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        chk("cmd_ready_before_accept", cmd_ready, 1);
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        cmd_addr = 12'($urandom()); cmd_wdata = $urandom(); cmd_size = 6'($urandom());
        m = 0; strobes = 0; bad = 0; got = 1'b0;
        while (!got && m < 40) begin
            @(negedge clock);
            m++;
            if (M_oe_ram && M_we_ram) bad++;
            if (M_oe_ram || M_we_ram) begin
                strobes++;
                if (M_we_ram !== we || M_oe_ram !== !we) bad++;
                if (M_addr_ram !== addr || M_Wdata_ram !== wdata || M_data_ram_size !== size) bad++;
                if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) bad++;
                S_DataRdy   = (strobes == delay);
                S_Rdata_ram = (strobes == delay) ? rsrc : $urandom();
            end else begin
                S_DataRdy   = 1'b0;
                S_Rdata_ram = $urandom();
            end
            if (rsp_valid) got = 1'b1;
        end
        chk("rsp_seen", got, 1);
        chk("rsp_latency", m, e_lat);
        chk("strobe_cycles", strobes, e_strobes);
        chk("strobe_bus_ok", bad, 0);
        chk("rsp_err", rsp_err, e_err);
        exp_rd = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, exp_rd);
        // Backpressure window: response held, no command accepted.
        hbad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            if (h == 1) begin
                cmd_valid = 1'b1; cmd_we = $urandom_range(0, 1); cmd_size = 6'd32;
            end else begin
                cmd_valid = 1'b0;
            end
            if (rsp_valid !== 1'b1 || rsp_err !== e_err || rsp_rdata !== exp_rd) hbad++;
            if (cmd_ready !== 1'b0 || M_oe_ram || M_we_ram) hbad++;
        end
        cmd_valid = 1'b0;
        if (hold > 0) chk("rsp_hold_stable", hbad, 0);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        chk("rsp_valid_dropped", rsp_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);
        // Nothing must start by itself afterwards (e.g. a stray command).
        if (hold > 0) begin
            hbad = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                if (M_oe_ram || M_we_ram || rsp_valid || !cmd_ready) hbad++;
            end
            chk("no_stray_accept", hbad, 0);
        end
    endtask

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [5:0]  size;
        int          delay;
        logic [31:0] rsrc;
        int          hold;
        logic        e_err;
        logic [31:0] e_rdata;
        int          e_strobes;
        int          e_lat;
    } vec_t;

    vec_t vecs[7];

    logic        r_we, m_err;
    logic [5:0]  r_size;
    logic [31:0] r_rsrc, m_rdata;
    int          r_delay, m_strobes, m_lat, bad;
    logic [5:0]  size_tab[6];

    initial begin
        vecs[0] = '{1'b1, 12'h040, 32'hDEADBEEF, 6'd32, 1, 32'h0,        0, 1'b0, 32'h0,        1, 2};
        vecs[1] = '{1'b0, 12'h044, 32'h0,        6'd16, 2, 32'h1234ABCD, 0, 1'b0, 32'h0000ABCD, 2, 3};
        vecs[2] = '{1'b1, 12'h048, 32'h11223344, 6'd24, 1, 32'h0,        0, 1'b1, 32'h0,        0, 1};
        vecs[3] = '{1'b0, 12'h04C, 32'h0,        6'd32, 0, 32'h0,        0, 1'b1, 32'h0,        4, 5};
        vecs[4] = '{1'b0, 12'h050, 32'h0,        6'd32, 1, 32'hCAFEF00D, 5, 1'b0, 32'hCAFEF00D, 1, 2};
        vecs[5] = '{1'b0, 12'h054, 32'h0,        6'd8,  4, 32'h123456A7, 0, 1'b0, 32'h000000A7, 4, 5};
        vecs[6] = '{1'b1, 12'hFFF, 32'h000000C3, 6'd8,  3, 32'h0,        0, 1'b0, 32'h0,        3, 4};
        size_tab = '{6'd8, 6'd16, 6'd32, 6'd24, 6'd0, 6'd33};

        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_size = '0;
        rsp_ready = 1'b0; S_DataRdy = 1'b0; S_Rdata_ram = '0;

        // Reset state.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_strobes", {M_oe_ram, M_we_ram}, 0);
        chk("reset_bus", {M_addr_ram, M_Wdata_ram, M_data_ram_size}, 0);
        reset = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].delay,
                   vecs[i].rsrc, vecs[i].hold, vecs[i].e_err, vecs[i].e_rdata,
                   vecs[i].e_strobes, vecs[i].e_lat);
        end

        // Timeout, then DataRdy pulses in IDLE must be ignored.
        do_txn(1'b0, 12'h060, 32'h0, 6'd16, 0, 32'h0, 0, 1'b1, 32'h0, TMO, TMO + 1);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            S_DataRdy = (i < 2); S_Rdata_ram = $urandom();
            if (M_oe_ram || M_we_ram || rsp_valid || !cmd_ready) bad++;
        end
        @(negedge clock);
        if (M_oe_ram || M_we_ram || rsp_valid || !cmd_ready) bad++;
        S_DataRdy = 1'b0;
        chk("idle_datardy_ignored", bad, 0);

        // Reset in strobe cycle 2 of a read whose responder would answer in cycle 3.
        @(negedge clock);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 12'h100; cmd_size = 6'd32;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        @(negedge clock);
        chk("midrst_strobe_c1", M_oe_ram, 1);
        @(negedge clock);
        chk("midrst_strobe_c2", M_oe_ram, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_strobe_async", {M_oe_ram, M_we_ram}, 0);
        chk("midrst_no_rsp", rsp_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        @(negedge clock);
        S_DataRdy = 1'b1; S_Rdata_ram = 32'hFFFFFFFF;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            S_DataRdy = 1'b0;
            if (M_oe_ram || M_we_ram || rsp_valid) bad++;
        end
        chk("midrst_abandoned", bad, 0);
        do_txn(1'b0, 12'h104, 32'h0, 6'd8, 1, 32'h00C0FF5A, 0, 1'b0, 32'h0000005A, 1, 2);

        // Randomized commands against the reference model.
        for (int i = 0; i < 40; i++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_size  = size_tab[$urandom_range(0, 5)];
            r_delay = $urandom_range(0, TMO + 2);
            r_rsrc  = $urandom();
            model(r_we, r_size, r_delay, r_rsrc, m_err, m_rdata, m_strobes, m_lat);
            do_txn(r_we, 12'($urandom()), $urandom(), r_size, r_delay, r_rsrc,
                   $urandom_range(0, 4), m_err, m_rdata, m_strobes, m_lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
